// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for a 4-digit seven-segment display fed by BCD digits.
// Frame-coherent snapshot of the digits, per-slot blanking gap, optional leading-zero blanking.
module seven_seg_scanner #(
  parameter int unsigned SCAN_DIV         = 1000,
  parameter int unsigned BLANK_CYCLES     = 16,
  parameter bit          ANODE_ACTIVE_LOW = 1'b1,
  parameter bit          SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       lz_suppress,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame_start
);

  localparam int unsigned  CW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYCLES);
  localparam logic [3:0]   AN_OFF   = ANODE_ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [6:0]   SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  typedef enum logic {PH_BLANK, PH_SHOW} phase_t;

  logic [1:0]    idx;
  logic [CW-1:0] cnt;
  logic [3:0]    snap [4];

  phase_t     phase;
  logic       frame_at;
  logic       suppress;
  logic       z1, z2, z3;
  logic [3:0] an_nxt;
  logic [6:0] seg_nxt;

  // Active-high {g,f,e,d,c,b,a}; non-BCD codes render as a dash.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b1000000;
    endcase
    return s;
  endfunction

  always_comb begin
    phase    = (cnt < CNT_SHOW) ? PH_BLANK : PH_SHOW;
    frame_at = (idx == 2'd0) && (cnt == '0);
    z3       = (snap[3] == 4'd0);
    z2       = z3 && (snap[2] == 4'd0);
    z1       = z2 && (snap[1] == 4'd0);
    case (idx)
      2'd1:    suppress = lz_suppress && z1;
      2'd2:    suppress = lz_suppress && z2;
      2'd3:    suppress = lz_suppress && z3;
      default: suppress = 1'b0;
    endcase
    an_nxt  = AN_OFF;
    seg_nxt = SEG_OFF;
    // XOR against the idle level applies either output polarity.
    if (phase == PH_SHOW && !suppress) begin
      an_nxt  = AN_OFF ^ (4'b0001 << idx);
      seg_nxt = SEG_OFF ^ decode(snap[idx]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      cnt <= '0;
      for (int unsigned i = 0; i < 4; i++) snap[i] <= '0;
      an          <= AN_OFF;
      seg         <= SEG_OFF;
      frame_start <= 1'b0;
    end else if (!en) begin
      idx         <= '0;
      cnt         <= '0;
      an          <= AN_OFF;
      seg         <= SEG_OFF;
      frame_start <= 1'b0;
    end else begin
      if (frame_at) begin
        snap[0] <= d0;
        snap[1] <= d1;
        snap[2] <= d2;
        snap[3] <= d3;
      end
      an          <= an_nxt;
      seg         <= seg_nxt;
      frame_start <= frame_at;
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner (SCAN_DIV=8, BLANK_CYCLES=2, active-low outputs).
// Expected per-digit segment patterns are hand-computed constants; 7'h7F marks a blank digit.
module tb_seven_seg_scanner;

  logic       clk = 1'b0;
  logic       rst, en, lz;
  logic [3:0] d0, d1, d2, d3;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame_start;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .SCAN_DIV(8),
    .BLANK_CYCLES(2),
    .ANODE_ACTIVE_LOW(1'b1),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .lz_suppress(lz),
    .d0(d0),
    .d1(d1),
    .d2(d2),
    .d3(d3),
    .an(an),
    .seg(seg),
    .frame_start(frame_start)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fs;
  } exp_t;

  exp_t       q[$];
  int         total = 0;
  int         bad   = 0;
  int         pos   = 0;
  logic [6:0] shown   [4];
  logic [6:0] pending [4];

  // Active-low segment constants
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000, SD = 7'b0111111, SB = 7'h7F;

  // Push the output expected after the coming posedge, then advance one cycle.
  task automatic step();
    exp_t e;
    int   slot;
    e.an  = 4'hF;
    e.seg = 7'h7F;
    e.fs  = 1'b0;
    if (rst || !en) begin
      pos = 0;
    end else begin
      if (pos == 0) shown = pending;
      slot = pos / 8;
      e.fs = (pos == 0);
      if ((pos % 8) >= 2 && shown[slot] != SB) begin
        e.an  = ~(4'b0001 << slot);
        e.seg = shown[slot];
      end
      pos = (pos + 1) % 32;
    end
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic set_case(input logic [3:0] a3, input logic [3:0] a2, input logic [3:0] a1,
                          input logic [3:0] a0, input logic l, input logic [6:0] s3,
                          input logic [6:0] s2, input logic [6:0] s1, input logic [6:0] s0);
    d3 = a3; d2 = a2; d1 = a1; d0 = a0; lz = l;
    pending[3] = s3; pending[2] = s2; pending[1] = s1; pending[0] = s0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if ({an, seg, frame_start} !== e) begin
          bad++;
          $display("FAIL out t=%0t an=%b seg=%b fs=%b expected an=%b seg=%b fs=%b",
                   $time, an, seg, frame_start, e.an, e.seg, e.fs);
        end
      end
    end
  end

  initial begin : stimulus
    rst = 1'b1; en = 1'b1;
    set_case(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, S0, S0, S0, S0);
    shown = pending;
    run(3);
    rst = 1'b0;
    set_case(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, S1, S2, S3, S4);
    run(64);
    set_case(4'd0, 4'd0, 4'd0, 4'd5, 1'b1, SB, SB, SB, S5);
    run(32);
    set_case(4'd0, 4'd0, 4'd0, 4'd5, 1'b0, S0, S0, S0, S5);
    run(32);
    set_case(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, SB, SB, SB, S0);
    run(32);
    set_case(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, S1, S2, S3, S4);
    run(16);
    d0 = 4'd7;
    pending[0] = S7;
    run(16);
    run(32);
    set_case(4'd0, 4'd0, 4'd0, 4'hA, 1'b0, S0, S0, S0, SD);
    run(32);
    set_case(4'd0, 4'd0, 4'hF, 4'hA, 1'b1, SB, SB, SD, SD);
    run(32);
    set_case(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, S1, S2, S3, S4);
    run(19);
    en = 1'b0;
    run(2);
    en = 1'b1;
    run(32);
    run(13);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(40);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
